// File: rtl/jtag_shift_master.sv
// JTAG shift master: turns SHIFT / TRST commands into TCK/TMS/TDI/TRSTn pin
// sequences and returns the captured TDO bits over a valid/ready response port.
`timescale 1ns/1ps
module jtag_shift_master #(
  parameter int CLK_DIV = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [4:0]  cmd_len,
  input  logic [31:0] cmd_tms,
  input  logic [31:0] cmd_tdi,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_tdo,
  output logic        rsp_err,
  output logic        tck_o,
  output logic        tms_o,
  output logic        tdi_o,
  output logic        trstn_o,
  input  logic        tdo_i,
  output logic        busy_o
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_SHIFT_LO  = 3'd1;
  localparam logic [2:0] S_SHIFT_HI  = 3'd2;
  localparam logic [2:0] S_TRST_HOLD = 3'd3;
  localparam logic [2:0] S_RESP      = 3'd4;

  localparam logic [1:0] OP_SHIFT = 2'b00;
  localparam logic [1:0] OP_TRST  = 2'b01;

  localparam logic [7:0] HALF_LAST = 8'(CLK_DIV - 1);

  logic [2:0]  r_state;
  logic [4:0]  r_len;
  logic [31:0] r_tms;
  logic [31:0] r_tdi;
  logic [4:0]  r_bit;
  logic [7:0]  r_half;
  logic        r_trstPhase;
  logic [31:0] r_tdo;
  logic        r_err;
  logic        r_tck;
  logic        r_tmsPin;
  logic        r_tdiPin;
  logic        r_trstn;

  logic        w_idle;
  logic        w_accept;
  logic        w_halfDone;
  logic        w_lastBit;
  logic [4:0]  w_nextBit;

  assign w_idle     = (r_state == S_IDLE);
  assign w_accept   = cmd_valid && cmd_ready;
  assign w_halfDone = (r_half == HALF_LAST);
  assign w_lastBit  = (r_bit == r_len);
  assign w_nextBit  = r_bit + 5'd1;

  // Handshake and status outputs are forced inactive while reset is held.
  assign cmd_ready = w_idle && !rst;
  assign busy_o    = !w_idle && !rst;
  assign rsp_valid = (r_state == S_RESP) && !rst;
  assign rsp_tdo   = r_tdo;
  assign rsp_err   = r_err;
  assign tck_o     = r_tck;
  assign tms_o     = r_tmsPin;
  assign tdi_o     = r_tdiPin;
  assign trstn_o   = r_trstn;

  // TRST reuses the per-bit timing: two half-periods per bit, r_trstPhase picks the half.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_half      <= 8'd0;
      r_bit       <= 5'd0;
      r_trstPhase <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_half      <= 8'd0;
            r_bit       <= 5'd0;
            r_trstPhase <= 1'b0;
            case (cmd_op)
              OP_SHIFT: r_state <= S_SHIFT_LO;
              OP_TRST:  r_state <= S_TRST_HOLD;
              default:  r_state <= S_RESP;
            endcase
          end
        end
        S_SHIFT_LO: begin
          if (w_halfDone) begin
            r_half  <= 8'd0;
            r_state <= S_SHIFT_HI;
          end else begin
            r_half <= r_half + 8'd1;
          end
        end
        S_SHIFT_HI: begin
          if (w_halfDone) begin
            r_half <= 8'd0;
            if (w_lastBit) begin
              r_state <= S_RESP;
            end else begin
              r_bit   <= w_nextBit;
              r_state <= S_SHIFT_LO;
            end
          end else begin
            r_half <= r_half + 8'd1;
          end
        end
        S_TRST_HOLD: begin
          if (w_halfDone) begin
            r_half      <= 8'd0;
            r_trstPhase <= !r_trstPhase;
            if (r_trstPhase) begin
              if (w_lastBit) begin
                r_state <= S_RESP;
              end else begin
                r_bit <= w_nextBit;
              end
            end
          end else begin
            r_half <= r_half + 8'd1;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_len <= 5'd0;
      r_tms <= 32'd0;
      r_tdi <= 32'd0;
    end else if (w_accept) begin
      r_len <= cmd_len;
      r_tms <= cmd_tms;
      r_tdi <= cmd_tdi;
    end
  end

  // The next bit is launched on the same edge that drops TCK, so the target sees
  // TMS/TDI settle a full half-period before it samples on the rising edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tck    <= 1'b0;
      r_tmsPin <= 1'b1;
      r_tdiPin <= 1'b0;
      r_trstn  <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept && cmd_op == OP_SHIFT) begin
            r_tck    <= 1'b0;
            r_tmsPin <= cmd_tms[0];
            r_tdiPin <= cmd_tdi[0];
          end else if (w_accept && cmd_op == OP_TRST) begin
            r_tck    <= 1'b0;
            r_tmsPin <= 1'b1;
            r_trstn  <= 1'b0;
          end
        end
        S_SHIFT_LO: begin
          if (w_halfDone) begin
            r_tck <= 1'b1;
          end
        end
        S_SHIFT_HI: begin
          if (w_halfDone) begin
            r_tck <= 1'b0;
            if (!w_lastBit) begin
              r_tmsPin <= r_tms[w_nextBit];
              r_tdiPin <= r_tdi[w_nextBit];
            end
          end
        end
        S_TRST_HOLD: begin
          if (w_halfDone && r_trstPhase && w_lastBit) begin
            r_trstn <= 1'b1;
          end
        end
        default: begin
          r_tck <= 1'b0;
        end
      endcase
    end
  end

  // TDO is sampled at the end of the high phase, just before TCK falls.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tdo <= 32'd0;
      r_err <= 1'b0;
    end else if (w_accept) begin
      r_tdo <= 32'd0;
      r_err <= cmd_op[1];
    end else if (r_state == S_SHIFT_HI && w_halfDone) begin
      r_tdo[r_bit] <= tdo_i;
    end
  end

endmodule

// File: tb/tb_jtag_shift_master.sv
// Bench for jtag_shift_master: three instances (CLK_DIV 2, 1, 4) in TDO=TDI loopback,
// checked every cycle against a cycle-count model plus hand-computed literals.
`timescale 1ns/1ps
module tb_jtag_shift_master;

  localparam int M_IDLE  = 0;
  localparam int M_SHIFT = 1;
  localparam int M_TRST  = 2;
  localparam int M_RESP  = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        rsp_ready;
  logic [1:0]  cmd_op;
  logic [4:0]  cmd_len;
  logic [31:0] cmd_tms;
  logic [31:0] cmd_tdi;

  logic        cmdReadyO [3];
  logic        rspValidO [3];
  logic        rspErrO   [3];
  logic        tckO      [3];
  logic        tmsO      [3];
  logic        tdiO      [3];
  logic        trstnO    [3];
  logic        busyO     [3];
  logic [31:0] rspTdoO   [3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : gDut
    jtag_shift_master #(.CLK_DIV((g == 0) ? 2 : ((g == 1) ? 1 : 4))) uDut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmdReadyO[g]),
      .cmd_op(cmd_op), .cmd_len(cmd_len), .cmd_tms(cmd_tms), .cmd_tdi(cmd_tdi),
      .rsp_valid(rspValidO[g]), .rsp_ready(rsp_ready),
      .rsp_tdo(rspTdoO[g]), .rsp_err(rspErrO[g]),
      .tck_o(tckO[g]), .tms_o(tmsO[g]), .tdi_o(tdiO[g]), .trstn_o(trstnO[g]),
      .tdo_i(tdiO[g]), .busy_o(busyO[g])
    );
  end

  function automatic int divOf(input int j);
    return (j == 0) ? 2 : ((j == 1) ? 1 : 4);
  endfunction

  // Model: mK counts cycles since acceptance; pins are derived from that count alone.
  int          mMode [3];
  int          mK    [3];
  int          mN    [3];
  logic [31:0] mTms  [3];
  logic [31:0] mTdi  [3];
  logic [31:0] mTdoExp [3];
  logic        mErr    [3];
  logic        mPinTms [3];
  logic        mPinTdi [3];
  logic        modelReady = 1'b0;

  always @(posedge clk) begin
    for (int j = 0; j < 3; j++) begin
      if (rst) begin
        mMode[j]   <= M_IDLE;
        mK[j]      <= 0;
        mPinTms[j] <= 1'b1;
        mPinTdi[j] <= 1'b0;
        mErr[j]    <= 1'b0;
        mTdoExp[j] <= 32'd0;
        modelReady <= 1'b1;
      end else begin
        case (mMode[j])
          M_IDLE: begin
            if (cmd_valid) begin
              mK[j]   <= 1;
              mN[j]   <= int'(cmd_len) + 1;
              mTms[j] <= cmd_tms;
              mTdi[j] <= cmd_tdi;
              mErr[j] <= cmd_op[1];
              if (cmd_op == 2'b00) begin
                mMode[j]   <= M_SHIFT;
                mTdoExp[j] <= (cmd_len == 5'd31) ? cmd_tdi
                              : (cmd_tdi & ((32'd1 << (cmd_len + 5'd1)) - 32'd1));
              end else begin
                mMode[j]   <= (cmd_op == 2'b01) ? M_TRST : M_RESP;
                mTdoExp[j] <= 32'd0;
              end
            end
          end
          M_SHIFT, M_TRST: begin
            if (mK[j] == 2 * divOf(j) * mN[j]) begin
              mMode[j] <= M_RESP;
              if (mMode[j] == M_SHIFT) begin
                mPinTms[j] <= mTms[j][mN[j] - 1];
                mPinTdi[j] <= mTdi[j][mN[j] - 1];
              end else begin
                mPinTms[j] <= 1'b1;
              end
            end else begin
              mK[j] <= mK[j] + 1;
            end
          end
          default: begin
            if (rsp_ready) mMode[j] <= M_IDLE;
          end
        endcase
      end
    end
  end

  task automatic checkOutput(input string name, input int j, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s[%0d]: got 0x%08h, expected 0x%08h at %0t", name, j, act, exp, $time);
    end
  endtask

  task automatic compareAll();
    int d, i, ph;
    logic eTck, eTms, eTdi, eTrstn, eValid;
    if (!modelReady) return;
    for (int j = 0; j < 3; j++) begin
      d      = divOf(j);
      eTck   = 1'b0;
      eTms   = mPinTms[j];
      eTdi   = mPinTdi[j];
      eTrstn = 1'b1;
      if (mMode[j] == M_SHIFT) begin
        i    = (mK[j] - 1) / (2 * d);
        ph   = (mK[j] - 1) % (2 * d);
        eTck = (ph >= d);
        eTms = mTms[j][i];
        eTdi = mTdi[j][i];
      end else if (mMode[j] == M_TRST) begin
        eTms   = 1'b1;
        eTrstn = 1'b0;
      end
      eValid = (mMode[j] == M_RESP) && !rst;
      checkOutput("cmd_ready", j, 32'(cmdReadyO[j]), 32'((mMode[j] == M_IDLE) && !rst));
      checkOutput("busy_o", j, 32'(busyO[j]), 32'((mMode[j] != M_IDLE) && !rst));
      checkOutput("rsp_valid", j, 32'(rspValidO[j]), 32'(eValid));
      checkOutput("tck_o", j, 32'(tckO[j]), 32'(eTck));
      checkOutput("tms_o", j, 32'(tmsO[j]), 32'(eTms));
      checkOutput("tdi_o", j, 32'(tdiO[j]), 32'(eTdi));
      checkOutput("trstn_o", j, 32'(trstnO[j]), 32'(eTrstn));
      if (eValid) begin
        checkOutput("rsp_tdo", j, rspTdoO[j], mTdoExp[j]);
        checkOutput("rsp_err", j, 32'(rspErrO[j]), 32'(mErr[j]));
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    compareAll();
  endtask

  int          respCyc [3];
  int          pulses  [3];
  int          trstLow [3];
  logic [31:0] tdiSeq  [3];
  logic [31:0] tmsSeq  [3];
  logic [31:0] recTdo  [3];
  logic [31:0] snapTdo [3];
  logic        recErr  [3];
  logic        prevTck [3];
  logic        snapValid [3];
  logic        snapReady [3];
  logic        snapErr   [3];

  // Issues one command to all instances and follows it until every instance is idle again.
  task automatic applyStimulus(input logic [1:0] op, input logic [4:0] len,
                               input logic [31:0] tms, input logic [31:0] tdi, input int holdLow);
    int  k;
    bit  done;
    cmd_op    = op;
    cmd_len   = len;
    cmd_tms   = tms;
    cmd_tdi   = tdi;
    cmd_valid = 1'b1;
    rsp_ready = (holdLow == 0);
    for (int j = 0; j < 3; j++) begin
      respCyc[j] = 0; pulses[j] = 0; trstLow[j] = 0;
      tdiSeq[j] = 32'd0; tmsSeq[j] = 32'd0; prevTck[j] = 1'b0;
      recTdo[j] = 32'hxxxxxxxx; recErr[j] = 1'bx;
      snapValid[j] = 1'b0; snapReady[j] = 1'b1; snapErr[j] = 1'b0; snapTdo[j] = 32'hxxxxxxxx;
    end
    tick();
    cmd_valid = 1'b0;
    cmd_op    = ~op;
    cmd_len   = ~len;
    cmd_tms   = ~tms;
    cmd_tdi   = ~tdi;
    k    = 1;
    done = 1'b0;
    while (!done && k <= 2000) begin
      for (int j = 0; j < 3; j++) begin
        if (rspValidO[j] && respCyc[j] == 0) begin
          respCyc[j] = k;
          recTdo[j]  = rspTdoO[j];
          recErr[j]  = rspErrO[j];
        end
        if (tckO[j] && !prevTck[j]) begin
          if (pulses[j] < 32) begin
            tdiSeq[j][pulses[j]] = tdiO[j];
            tmsSeq[j][pulses[j]] = tmsO[j];
          end
          pulses[j]++;
        end
        prevTck[j] = tckO[j];
        if (!trstnO[j]) trstLow[j]++;
      end
      if (k == holdLow) begin
        for (int j = 0; j < 3; j++) begin
          snapValid[j] = rspValidO[j];
          snapReady[j] = cmdReadyO[j];
          snapErr[j]   = rspErrO[j];
          snapTdo[j]   = rspTdoO[j];
        end
        rsp_ready = 1'b1;
      end
      done = 1'b1;
      for (int j = 0; j < 3; j++) begin
        if (respCyc[j] == 0 || !cmdReadyO[j]) done = 1'b0;
      end
      if (!done) begin
        tick();
        k++;
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("[TB] FAIL cmd_timeout: got no completion after %0d cycles, expected completion", k);
    end
  endtask

  initial begin
    bit sawValid;
    rst       = 1'b1;
    cmd_valid = 1'b0;
    rsp_ready = 1'b0;
    cmd_op    = 2'b00;
    cmd_len   = 5'd0;
    cmd_tms   = 32'd0;
    cmd_tdi   = 32'd0;

    repeat (3) tick();
    checkOutput("rst_cmd_ready", 0, 32'(cmdReadyO[0]), 32'd0);
    checkOutput("rst_tms", 0, 32'(tmsO[0]), 32'd1);
    checkOutput("rst_tck", 0, 32'(tckO[0]), 32'd0);
    checkOutput("rst_trstn", 0, 32'(trstnO[0]), 32'd1);
    checkOutput("rst_busy", 0, 32'(busyO[0]), 32'd0);
    checkOutput("rst_rsp_tdo", 0, rspTdoO[0], 32'd0);
    rst = 1'b0;
    tick();
    for (int j = 0; j < 3; j++) checkOutput("ready_after_rst", j, 32'(cmdReadyO[j]), 32'd1);

    $display("[TB] 8-bit shift, loopback");
    applyStimulus(2'b00, 5'd7, 32'h80, 32'hA5, 0);
    checkOutput("s8_pulses", 0, 32'(pulses[0]), 32'd8);
    checkOutput("s8_tdi_seq", 0, tdiSeq[0], 32'h000000A5);
    checkOutput("s8_tms_seq", 0, tmsSeq[0], 32'h00000080);
    checkOutput("s8_rsp_cycle", 0, 32'(respCyc[0]), 32'd33);
    checkOutput("s8_rsp_tdo", 0, recTdo[0], 32'h000000A5);
    checkOutput("s8_rsp_err", 0, 32'(recErr[0]), 32'd0);
    checkOutput("s8_rsp_cycle", 1, 32'(respCyc[1]), 32'd17);
    checkOutput("s8_rsp_cycle", 2, 32'(respCyc[2]), 32'd65);

    $display("[TB] 32-bit and 1-bit shifts");
    applyStimulus(2'b00, 5'd31, 32'h12345678, 32'hDEADBEEF, 0);
    checkOutput("s32_rsp_cycle", 1, 32'(respCyc[1]), 32'd65);
    checkOutput("s32_rsp_tdo", 1, recTdo[1], 32'hDEADBEEF);
    checkOutput("s32_pulses", 1, 32'(pulses[1]), 32'd32);
    checkOutput("s32_tms_seq", 1, tmsSeq[1], 32'h12345678);
    applyStimulus(2'b00, 5'd0, 32'h1, 32'hDEADBEEF, 0);
    checkOutput("s1_pulses", 1, 32'(pulses[1]), 32'd1);
    checkOutput("s1_rsp_tdo", 1, recTdo[1], 32'h00000001);
    checkOutput("s1_rsp_cycle", 1, 32'(respCyc[1]), 32'd3);

    $display("[TB] 13-bit shift, upper TDO bits cleared");
    applyStimulus(2'b00, 5'd12, 32'h00001F0F, 32'h00005C3A, 0);
    checkOutput("s13_rsp_tdo", 0, recTdo[0], 32'h00001C3A);
    checkOutput("s13_rsp_cycle", 2, 32'(respCyc[2]), 32'd105);

    $display("[TB] TRST");
    applyStimulus(2'b01, 5'd4, 32'h0, 32'h0, 0);
    checkOutput("trst_low_cycles", 2, 32'(trstLow[2]), 32'd40);
    checkOutput("trst_low_cycles", 0, 32'(trstLow[0]), 32'd20);
    checkOutput("trst_pulses", 2, 32'(pulses[2]), 32'd0);
    checkOutput("trst_rsp_tdo", 2, recTdo[2], 32'd0);
    checkOutput("trst_rsp_err", 2, 32'(recErr[2]), 32'd0);
    checkOutput("trst_rsp_cycle", 2, 32'(respCyc[2]), 32'd41);

    $display("[TB] reserved opcodes");
    applyStimulus(2'b11, 5'd7, 32'hFFFFFFFF, 32'hFFFFFFFF, 10);
    for (int j = 0; j < 3; j++) begin
      checkOutput("rsv_rsp_cycle", j, 32'(respCyc[j]), 32'd1);
      checkOutput("rsv_rsp_err", j, 32'(recErr[j]), 32'd1);
      checkOutput("rsv_pulses", j, 32'(pulses[j]), 32'd0);
    end
    checkOutput("rsv_hold_valid", 0, 32'(snapValid[0]), 32'd1);
    checkOutput("rsv_hold_ready", 0, 32'(snapReady[0]), 32'd0);
    checkOutput("rsv_hold_err", 0, 32'(snapErr[0]), 32'd1);
    checkOutput("rsv_hold_tdo", 0, snapTdo[0], 32'd0);
    applyStimulus(2'b10, 5'd3, 32'h0, 32'h0, 0);
    checkOutput("rsv10_rsp_err", 1, 32'(recErr[1]), 32'd1);

    $display("[TB] reset during bit 3");
    cmd_op    = 2'b00;
    cmd_len   = 5'd7;
    cmd_tms   = 32'h80;
    cmd_tdi   = 32'hA5;
    cmd_valid = 1'b1;
    rsp_ready = 1'b1;
    tick();
    cmd_valid = 1'b0;
    repeat (13) tick();
    checkOutput("pre_abort_busy", 0, 32'(busyO[0]), 32'd1);
    rst = 1'b1;
    tick();
    checkOutput("abort_tck", 0, 32'(tckO[0]), 32'd0);
    checkOutput("abort_tms", 0, 32'(tmsO[0]), 32'd1);
    checkOutput("abort_tdi", 0, 32'(tdiO[0]), 32'd0);
    checkOutput("abort_trstn", 0, 32'(trstnO[0]), 32'd1);
    checkOutput("abort_rsp_valid", 0, 32'(rspValidO[0]), 32'd0);
    rst = 1'b0;
    tick();
    for (int j = 0; j < 3; j++) checkOutput("abort_ready", j, 32'(cmdReadyO[j]), 32'd1);
    sawValid = 1'b0;
    repeat (40) begin
      tick();
      for (int j = 0; j < 3; j++) if (rspValidO[j]) sawValid = 1'b1;
    end
    checkOutput("abort_no_rsp", 0, 32'(sawValid), 32'd0);
    applyStimulus(2'b00, 5'd7, 32'h80, 32'hA5, 0);
    checkOutput("post_abort_tdo", 0, recTdo[0], 32'h000000A5);
    checkOutput("post_abort_cycle", 0, 32'(respCyc[0]), 32'd33);

    repeat (2) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
